// File: rtl/matmul_pkg.sv
// Shared types for the matmul stream controller.
// State encoding and matrix element count helper.
package matmul_pkg;

  typedef enum logic [2:0] {
    LOAD_X,
    LOAD_Y,
    START,
    WAIT_LO,
    WAIT_HI,
    DRAIN
  } matmul_stream_state_t;

  function automatic int elems(input int vs);
    return vs * vs;
  endfunction

endpackage

// File: rtl/matmul_out_fifo.sv
// Two-entry synchronous FIFO for the result stream.
// Push and pop together on a full FIFO keep occupancy unchanged.
module matmul_out_fifo #(
  parameter int W = 33
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_pop;
  logic         do_push;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/matmul_stream_ctrl.sv
// Stream controller around the matmul core: loads X/Y BRAMs,
// kicks the core, then streams Z back out with a last flag.
module matmul_stream_ctrl
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int VECTOR_SIZE = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] x_din,
  output logic [ADDR_WIDTH-1:0] x_wr_addr,
  output logic                  x_wr_en,
  output logic [DATA_WIDTH-1:0] y_din,
  output logic [ADDR_WIDTH-1:0] y_wr_addr,
  output logic                  y_wr_en,
  output logic                  mm_start,
  input  logic                  mm_done,
  output logic [ADDR_WIDTH-1:0] z_addr,
  input  logic [DATA_WIDTH-1:0] z_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int N  = elems(VECTOR_SIZE);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] NUM  = CW'(N);

  matmul_stream_state_t state;
  logic [CW-1:0]   wr_cnt;
  logic [CW-1:0]   rd_cnt;
  logic            inflight;
  logic            inflight_last;
  logic [1:0]      fifo_cnt;
  logic            fifo_full;
  logic            fifo_empty;
  logic            head_last;
  logic [DATA_WIDTH-1:0] head_data;
  logic            pop;
  logic            xfer;
  logic            issue;
  logic [2:0]      credits;

  assign in_ready  = !reset && (state == LOAD_X || state == LOAD_Y);
  assign xfer      = in_valid && in_ready;
  assign busy      = (state != LOAD_X) || (wr_cnt != '0);
  assign out_valid = !fifo_empty;
  assign out_data  = head_data;
  assign out_last  = out_valid && head_last;
  assign pop       = out_valid && out_ready;
  assign z_addr    = rd_cnt[ADDR_WIDTH-1:0];

  // Reads in flight plus buffered words never exceed the FIFO depth.
  assign credits = {2'b0, inflight} + {1'b0, fifo_cnt} - {2'b0, pop};
  assign issue   = (state == DRAIN) && (rd_cnt < NUM)
                && (credits < 3'd2) && !(fifo_full && !pop);

  matmul_out_fifo #(
    .W(DATA_WIDTH + 1)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (inflight),
    .pop  (pop),
    .din  ({inflight_last, z_dout}),
    .dout ({head_last, head_data}),
    .count(fifo_cnt),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= LOAD_X;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      x_din         <= '0;
      x_wr_addr     <= '0;
      x_wr_en       <= 1'b0;
      y_din         <= '0;
      y_wr_addr     <= '0;
      y_wr_en       <= 1'b0;
      mm_start      <= 1'b0;
    end else begin
      x_wr_en       <= 1'b0;
      y_wr_en       <= 1'b0;
      mm_start      <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (rd_cnt == LAST);
      unique case (state)
        LOAD_X: begin
          if (xfer) begin
            x_din     <= in_data;
            x_wr_addr <= wr_cnt[ADDR_WIDTH-1:0];
            x_wr_en   <= 1'b1;
            if (wr_cnt == LAST) begin
              wr_cnt <= '0;
              state  <= LOAD_Y;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        LOAD_Y: begin
          if (xfer) begin
            y_din     <= in_data;
            y_wr_addr <= wr_cnt[ADDR_WIDTH-1:0];
            y_wr_en   <= 1'b1;
            if (wr_cnt == LAST) begin
              wr_cnt <= '0;
              state  <= START;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        START: begin
          mm_start <= 1'b1;
          state    <= WAIT_LO;
        end
        // Skip a done level left over from the previous run.
        WAIT_LO: if (!mm_done) state <= WAIT_HI;
        WAIT_HI: begin
          if (mm_done) begin
            rd_cnt <= '0;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (issue) rd_cnt <= rd_cnt + 1'b1;
          if (pop && head_last) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
            state  <= LOAD_X;
          end
        end
        default: state <= LOAD_X;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Scoreboard bench for matmul_stream_ctrl with a behavioural
// matmul core, BRAM models and a matrix-product reference.
module tb_matmul_stream_ctrl;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int VS = 2;
  localparam int N  = VS * VS;

  typedef struct {
    bit          y;
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] d;
    bit          last;
  } out_t;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x_din;
  logic [AW-1:0] x_wr_addr;
  logic          x_wr_en;
  logic [DW-1:0] y_din;
  logic [AW-1:0] y_wr_addr;
  logic          y_wr_en;
  logic          mm_start;
  logic          mm_done;
  logic [AW-1:0] z_addr;
  logic [DW-1:0] z_dout;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;

  matmul_stream_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .VECTOR_SIZE(VS)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_din    (x_din),
    .x_wr_addr(x_wr_addr),
    .x_wr_en  (x_wr_en),
    .y_din    (y_din),
    .y_wr_addr(y_wr_addr),
    .y_wr_en  (y_wr_en),
    .mm_start (mm_start),
    .mm_done  (mm_done),
    .z_addr   (z_addr),
    .z_dout   (z_dout),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  wr_t  wq[$];
  out_t oq[$];
  logic [31:0] xmem [64];
  logic [31:0] ymem [64];
  logic [31:0] zmem [64];
  int  last_acc_cyc = 0;
  int  rise_cyc = 0;
  bit  drain_allowed = 0;
  bit  expect_first = 0;
  bit  chk_idle = 0;
  int  ready_mode = 0;
  int  pi = 0;
  int  vpat [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
  int  rpat [7] = '{1, 0, 0, 1, 1, 0, 1};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // BRAM models: captured X/Y writes, registered Z read.
  always @(posedge clock) begin
    if (x_wr_en) xmem[x_wr_addr] <= x_din;
    if (y_wr_en) ymem[y_wr_addr] <= y_din;
    z_dout <= zmem[z_addr];
  end

  initial begin
    int rk = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = rpat[rk % 7] != 0; rk++; end
        default: out_ready = ($urandom % 100) < 65;
      endcase
    end
  end

  // Behavioural matmul core working from the captured BRAMs.
  initial begin
    mm_done = 1'b1;
    forever begin
      @(negedge clock);
      if (!reset && mm_start) begin
        chk("start_lat", cyc, last_acc_cyc + 2);
        @(negedge clock);
        chk("start_pulse", mm_start, 0);
        repeat ($urandom_range(1, 4)) @(posedge clock);
        #1 mm_done = 1'b0;
        repeat ($urandom_range(2, 12)) @(posedge clock);
        for (int i = 0; i < VS; i++)
          for (int j = 0; j < VS; j++) begin
            logic [31:0] s;
            s = 0;
            for (int k = 0; k < VS; k++)
              s += xmem[i*VS+k] * ymem[k*VS+j];
            zmem[i*VS+j] = s;
          end
        #1 mm_done = 1'b1;
        rise_cyc = cyc;
        drain_allowed = 1;
        expect_first = 1;
      end
    end
  end

  task automatic mon_wr(input bit y, input logic [5:0] a,
                        input logic [31:0] d);
    wr_t e;
    if (wq.size() == 0) begin
      chk("spurious_wr", {y, a, d}, 0);
    end else begin
      e = wq.pop_front();
      chk(y ? "y_wr" : "x_wr", {y, a, d}, {e.y, e.addr, e.data});
    end
  endtask

  initial begin
    int acc = 0;
    int prev_pop_cyc = 0;
    bit prev_stall = 0;
    logic [31:0] prev_data = 0;
    logic prev_last = 0;
    out_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (chk_idle) begin
          chk("idle_ready", in_ready, 1);
          chk("idle_busy", busy, 0);
          chk_idle = 0;
        end
        if (x_wr_en) mon_wr(0, x_wr_addr, x_din);
        if (y_wr_en) mon_wr(1, y_wr_addr, y_din);
        if (prev_stall) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, prev_data);
          chk("stall_last", out_last, prev_last);
        end
        if (out_valid) begin
          chk("drain_gate", drain_allowed, 1);
          chk("z_ahead", int'(z_addr) <= acc + 2, 1);
          if (expect_first) begin
            chk("first_lat", cyc, rise_cyc + 3);
            expect_first = 0;
          end
        end
        if (out_valid && out_ready) begin
          if (oq.size() == 0) begin
            chk("spurious_out", out_data, 0);
          end else begin
            e = oq.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_last", out_last, e.last);
            if (ready_mode == 0 && acc > 0)
              chk("thruput", cyc, prev_pop_cyc + 1);
            prev_pop_cyc = cyc;
            acc++;
            if (e.last) begin
              acc = 0;
              drain_allowed = 0;
              chk_idle = 1;
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end else begin
        prev_stall = 0;
        chk_idle = 0;
        acc = 0;
      end
    end
  end

  task automatic send(input logic [31:0] w);
    int k = 0;
    in_data  = w;
    in_valid = 1'b1;
    forever begin
      @(negedge clock);
      if (in_ready && !reset) break;
      k++;
      if (k > 3000) begin
        chk("accept_timeout", 1, 0);
        break;
      end
    end
    last_acc_cyc = cyc;
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic load_run(input int nwords, input int gmode,
                          input bit fixed);
    logic [31:0] a [N];
    logic [31:0] b [N];
    logic [31:0] w;
    for (int i = 0; i < nwords; i++) begin
      w = fixed ? 32'(i + 1) : $urandom;
      if (gmode == 1) begin
        while (vpat[pi % 9] == 0) begin
          in_valid = 1'b0;
          @(posedge clock);
          #1 pi++;
        end
        pi++;
      end else if (gmode == 2) begin
        while (($urandom % 100) < 30) begin
          in_valid = 1'b0;
          @(posedge clock);
          #1;
        end
      end
      send(w);
      if (i < N) begin
        a[i] = w;
        wq.push_back('{y: 1'b0, addr: 6'(i), data: w});
      end else begin
        b[i-N] = w;
        wq.push_back('{y: 1'b1, addr: 6'(i - N), data: w});
      end
    end
    in_valid = 1'b0;
    if (nwords == 2 * N) begin
      for (int r = 0; r < VS; r++)
        for (int c = 0; c < VS; c++) begin
          logic [31:0] s;
          s = 0;
          for (int k = 0; k < VS; k++)
            s += a[r*VS+k] * b[k*VS+c];
          oq.push_back('{d: s, last: (r*VS+c) == N - 1});
        end
    end
  endtask

  task automatic wait_drained();
    int k = 0;
    while (oq.size() != 0 && k < 3000) begin
      @(posedge clock);
      k++;
    end
    if (k >= 3000) chk("drain_timeout", oq.size(), 0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_x", {x_wr_en, x_wr_addr, x_din}, 0);
    chk("rst_y", {y_wr_en, y_wr_addr, y_din}, 0);
    chk("rst_ctl", {mm_start, z_addr, out_valid, out_last, busy}, 0);
    chk("rst_out", out_data, 0);
    reset = 1'b0;
    #1 chk("post_rst_ready", in_ready, 1);

    ready_mode = 0;
    load_run(2 * N, 0, 1);
    wait_drained();

    ready_mode = 1;
    load_run(2 * N, 1, 0);
    wait_drained();

    ready_mode = 2;
    load_run(N + 2, 0, 0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_x", {x_wr_en, x_wr_addr, x_din}, 0);
    chk("arst_y", {y_wr_en, y_wr_addr, y_din}, 0);
    chk("arst_ctl", {mm_start, z_addr, out_valid, out_last, busy}, 0);
    chk("arst_out", out_data, 0);
    chk("arst_wq", wq.size(), 0);
    wq.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    #1 chk("arst_ready", in_ready, 1);

    load_run(2 * N, 0, 0);
    for (int r = 0; r < 3; r++) load_run(2 * N, 2, 0);
    wait_drained();
    chk("final_wq", wq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
